// File: rtl/goods_key_input_pkg.sv
// Shared vending-machine constants: one-hot main FSM state codes, timing limits
// and the goods selection encoding widths used by the display and the FSM.
package vending_pkg;

   localparam logic [5:0] IDLE      = 6'h01;
   localparam logic [5:0] GOODS_one = 6'h02;
   localparam logic [5:0] GOODS_two = 6'h04;
   localparam logic [5:0] PAYMENT   = 6'h08;
   localparam logic [5:0] CHANGE    = 6'h10;
   localparam logic [5:0] TEMP      = 6'h20;

   localparam logic [25:0] CNT_MAX     = 26'd49_999_999;
   localparam logic [19:0] DEB_CNT_MAX = 20'd999_999;

   localparam int GOODS_HIGH_W = 3;
   localparam int GOODS_LOW_W  = 3;
   localparam int GOODS_NUM_W  = 2;
   localparam int GOODS_SEL_W  = GOODS_HIGH_W + GOODS_LOW_W;

   // Conditioned key vector layout: [5:0] goods, then quantity, confirm, cancel.
   localparam int KEY_NUM         = GOODS_SEL_W + 3;
   localparam int KEY_NUM_IDX     = GOODS_SEL_W;
   localparam int KEY_CONFIRM_IDX = GOODS_SEL_W + 1;
   localparam int KEY_CANCEL_IDX  = GOODS_SEL_W + 2;

   // Isolates the lowest set bit, so the lowest pressed goods index wins.
   function automatic logic [GOODS_SEL_W-1:0] lowest_onehot(input logic [GOODS_SEL_W-1:0] v);
      return v & (~v + {{(GOODS_SEL_W-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/goods_key_input_if.sv
// Goods selection bus from the front-panel input block to the display and main FSM.
interface goods_key_input_if;
   import vending_pkg::*;

   logic [GOODS_HIGH_W-1:0] goods_high;
   logic [GOODS_LOW_W-1:0]  goods_low;
   logic [GOODS_NUM_W-1:0]  goods_num;
   logic                    sel_valid;
   logic                    cancel_pulse;
   logic                    wake_pulse;

   modport master (
      output goods_high, goods_low, goods_num, sel_valid, cancel_pulse, wake_pulse
   );

   modport slave (
      input  goods_high, goods_low, goods_num, sel_valid, cancel_pulse, wake_pulse
   );

endinterface

// File: rtl/goods_key_input_key_debounce.sv
// One button: 2-flop synchronizer, saturating stable-level counter, and a
// registered rising-edge pulse on the accepted level.
module key_debounce #(
   parameter logic [19:0] DEB_CNT_MAX = vending_pkg::DEB_CNT_MAX
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic key_press
);

   logic        sync1_reg;
   logic        sync2_reg;
   logic        level_reg;
   logic        level_d_reg;
   logic [19:0] cnt_reg;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         level_reg   <= 1'b0;
         level_d_reg <= 1'b0;
         cnt_reg     <= 20'd0;
         key_press   <= 1'b0;
      end else begin
         sync1_reg   <= key_in;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_reg;
         key_press   <= level_reg & ~level_d_reg;
         // Count only while the synced level disagrees with the accepted one.
         if (sync2_reg == level_reg) begin
            cnt_reg <= 20'd0;
         end else if (cnt_reg != DEB_CNT_MAX) begin
            cnt_reg <= cnt_reg + 20'd1;
         end else begin
            level_reg <= sync2_reg;
         end
      end
   end

endmodule

// File: rtl/goods_key_input.sv
// Front-panel input block: debounces nine buttons and maintains the goods
// selection plus confirm / cancel / wake pulses according to the main FSM state.
module goods_key_input
   import vending_pkg::*;
#(
   parameter logic [19:0] DEB_CNT_MAX = vending_pkg::DEB_CNT_MAX
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [5:0]             state,
   input  logic [GOODS_SEL_W-1:0] btn_sel,
   input  logic                   btn_num,
   input  logic                   btn_confirm,
   input  logic                   btn_cancel,
   goods_key_input_if.master      goods_if
);

   logic [KEY_NUM-1:0]      key_raw;
   logic [KEY_NUM-1:0]      key_press;
   logic [GOODS_SEL_W-1:0]  sel_onehot;
   logic                    sel_present;

   logic [GOODS_HIGH_W-1:0] goods_high_reg, goods_high_next;
   logic [GOODS_LOW_W-1:0]  goods_low_reg,  goods_low_next;
   logic [GOODS_NUM_W-1:0]  goods_num_reg,  goods_num_next;
   logic                    sel_valid_reg,  sel_valid_next;
   logic                    cancel_reg,     cancel_next;
   logic                    wake_reg,       wake_next;

   assign key_raw = {btn_cancel, btn_confirm, btn_num, btn_sel};

   generate
      for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
         key_debounce #(.DEB_CNT_MAX(DEB_CNT_MAX)) u_key_debounce (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_in    (key_raw[gi]),
            .key_press (key_press[gi])
         );
      end
   endgenerate

   assign sel_onehot  = lowest_onehot(key_press[GOODS_SEL_W-1:0]);
   assign sel_present = |{goods_high_reg, goods_low_reg};

   always_comb begin
      goods_high_next = goods_high_reg;
      goods_low_next  = goods_low_reg;
      goods_num_next  = goods_num_reg;
      sel_valid_next  = 1'b0;
      cancel_next     = 1'b0;
      wake_next       = 1'b0;
      if (state == IDLE) begin
         goods_high_next = '0;
         goods_low_next  = '0;
         goods_num_next  = '0;
         wake_next       = |key_press;
      end else if (state == GOODS_one || state == GOODS_two) begin
         // Strict priority; lower-priority presses in the same cycle are dropped.
         if (key_press[KEY_CANCEL_IDX]) begin
            goods_high_next = '0;
            goods_low_next  = '0;
            goods_num_next  = '0;
            cancel_next     = 1'b1;
         end else if (key_press[KEY_CONFIRM_IDX]) begin
            sel_valid_next = sel_present;
         end else if (|key_press[GOODS_SEL_W-1:0]) begin
            goods_low_next  = sel_onehot[GOODS_LOW_W-1:0];
            goods_high_next = sel_onehot[GOODS_SEL_W-1:GOODS_LOW_W];
            if (goods_num_reg == 2'd0) goods_num_next = 2'd1;
         end else if (key_press[KEY_NUM_IDX] && sel_present) begin
            goods_num_next = (goods_num_reg == 2'd3) ? 2'd1 : goods_num_reg + 2'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         goods_high_reg <= '0;
         goods_low_reg  <= '0;
         goods_num_reg  <= '0;
         sel_valid_reg  <= 1'b0;
         cancel_reg     <= 1'b0;
         wake_reg       <= 1'b0;
      end else begin
         goods_high_reg <= goods_high_next;
         goods_low_reg  <= goods_low_next;
         goods_num_reg  <= goods_num_next;
         sel_valid_reg  <= sel_valid_next;
         cancel_reg     <= cancel_next;
         wake_reg       <= wake_next;
      end
   end

   assign goods_if.goods_high   = goods_high_reg;
   assign goods_if.goods_low    = goods_low_reg;
   assign goods_if.goods_num    = goods_num_reg;
   assign goods_if.sel_valid    = sel_valid_reg;
   assign goods_if.cancel_pulse = cancel_reg;
   assign goods_if.wake_pulse   = wake_reg;

endmodule
